// File: rtl/multdiv_issue_ctrl_if.sv
// Request, unit and response signals of the multiply/divide issue controller.
// Signal names follow the controller's port naming so both sides read alike.
//   slave  : the issue controller (accepts requests, drives the unit, returns results)
//   master : the requester / unit model (drives requests, unit valid/result, consumes responses)
// Groups:
//   request  : req_valid_i, req_ready_o, req_operator_i, req_signed_mode_i,
//              req_op_a_i, req_op_b_i, data_ind_timing_i, flush_i
//   unit     : mult_en_o, div_en_o, mult_sel_o, div_sel_o, operator_o, signed_mode_o,
//              op_a_o, op_b_o, multdiv_ready_id_o, valid_i, result_i
//   response : rsp_valid_o, rsp_ready_i, rsp_result_o
//   status   : busy_o, timing_err_o, timeout_err_o, err_clear_i
interface multdiv_issue_ctrl_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  req_operator_i;
  logic [1:0]  req_signed_mode_i;
  logic [31:0] req_op_a_i;
  logic [31:0] req_op_b_i;
  logic        data_ind_timing_i;
  logic        flush_i;

  logic        mult_en_o;
  logic        div_en_o;
  logic        mult_sel_o;
  logic        div_sel_o;
  logic [1:0]  operator_o;
  logic [1:0]  signed_mode_o;
  logic [31:0] op_a_o;
  logic [31:0] op_b_o;
  logic        multdiv_ready_id_o;
  logic        valid_i;
  logic [31:0] result_i;

  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_result_o;

  logic        busy_o;
  logic        timing_err_o;
  logic        timeout_err_o;
  logic        err_clear_i;

  modport slave (
    input  req_valid_i, req_operator_i, req_signed_mode_i, req_op_a_i, req_op_b_i,
           data_ind_timing_i, flush_i, valid_i, result_i, rsp_ready_i, err_clear_i,
    output req_ready_o, mult_en_o, div_en_o, mult_sel_o, div_sel_o, operator_o,
           signed_mode_o, op_a_o, op_b_o, multdiv_ready_id_o, rsp_valid_o,
           rsp_result_o, busy_o, timing_err_o, timeout_err_o
  );

  modport master (
    output req_valid_i, req_operator_i, req_signed_mode_i, req_op_a_i, req_op_b_i,
           data_ind_timing_i, flush_i, valid_i, result_i, rsp_ready_i, err_clear_i,
    input  req_ready_o, mult_en_o, div_en_o, mult_sel_o, div_sel_o, operator_o,
           signed_mode_o, op_a_o, op_b_o, multdiv_ready_id_o, rsp_valid_o,
           rsp_result_o, busy_o, timing_err_o, timeout_err_o
  );
endinterface

// File: rtl/multdiv_issue_ctrl.sv
// ID-side initiator for the multiply/divide unit.
// Accepts one request, registers operator/mode/operands, drives the unit's
// enable/select inputs until the unit reports valid, then holds the result on
// a valid/ready response port. With data-independent timing enabled, each op
// must complete in exactly MulCycles/DivCycles cycles (sticky timing_err_o);
// an op still outstanding at TimeoutCycles is aborted (sticky timeout_err_o).
// Ports:
//   clk_i  : clock
//   rst_ni : synchronous active-low reset
//   md     : multdiv_issue_ctrl_if.slave (request, unit, response, status groups)
module multdiv_issue_ctrl #(
  parameter int unsigned MulCycles     = 33,
  parameter int unsigned DivCycles     = 37,
  parameter int unsigned TimeoutCycles = 63
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  multdiv_issue_ctrl_if.slave  md
);

  localparam logic [5:0] MulCnt = 6'(MulCycles);
  localparam logic [5:0] DivCnt = 6'(DivCycles);
  localparam logic [5:0] ToCnt  = 6'(TimeoutCycles);
  localparam logic [5:0] CntMax = 6'd63;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [1:0]  operator_q;
  logic [1:0]  signed_mode_q;
  logic [31:0] op_a_q, op_b_q;
  logic [31:0] result_q;
  logic        dit_q;
  logic        timing_err_q, timeout_err_q;

  logic        req_ready;
  logic        accept;
  logic        capture;
  logic        timing_set;
  logic        timeout_set;
  logic        is_mult;
  logic [5:0]  exp_cnt;

  // MULL/MULH are encodings 0/1, DIV/REM are 2/3.
  assign is_mult = ~operator_q[1];
  assign exp_cnt = is_mult ? MulCnt : DivCnt;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready   = 1'b0;
    accept      = 1'b0;
    capture     = 1'b0;
    timing_set  = 1'b0;
    timeout_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = ~md.flush_i;
        accept    = req_ready & md.req_valid_i;
        if (accept) begin
          state_d = ISSUE;
          cnt_d   = 6'd1;
        end
      end
      ISSUE: begin
        // Flush outranks a simultaneous unit valid: the result is discarded.
        if (md.flush_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (md.valid_i) begin
          capture    = 1'b1;
          timing_set = dit_q & (cnt_q != exp_cnt);
          state_d    = RESP;
          cnt_d      = '0;
        end else if (cnt_q == ToCnt) begin
          timeout_set = 1'b1;
          state_d     = IDLE;
          cnt_d       = '0;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      RESP: begin
        // Consuming the response frees the slot, so a new request can be
        // taken in the same cycle without an idle bubble.
        req_ready = md.rsp_ready_i & ~md.flush_i;
        accept    = req_ready & md.req_valid_i;
        if (md.flush_i) begin
          state_d = IDLE;
        end else if (md.rsp_ready_i) begin
          state_d = accept ? ISSUE : IDLE;
          cnt_d   = accept ? 6'd1 : 6'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      timing_err_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      // A new error event outranks a clear in the same cycle.
      timing_err_q  <= (timing_err_q & ~md.err_clear_i) | timing_set;
      timeout_err_q <= (timeout_err_q & ~md.err_clear_i) | timeout_set;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      operator_q    <= '0;
      signed_mode_q <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      dit_q         <= 1'b0;
      result_q      <= '0;
    end else begin
      if (accept) begin
        operator_q    <= md.req_operator_i;
        signed_mode_q <= md.req_signed_mode_i;
        op_a_q        <= md.req_op_a_i;
        op_b_q        <= md.req_op_b_i;
        dit_q         <= md.data_ind_timing_i;
      end
      if (capture) begin
        result_q <= md.result_i;
      end
    end
  end

  assign md.req_ready_o        = req_ready;
  assign md.mult_en_o          = (state_q == ISSUE) & is_mult;
  assign md.mult_sel_o         = (state_q == ISSUE) & is_mult;
  assign md.div_en_o           = (state_q == ISSUE) & ~is_mult;
  assign md.div_sel_o          = (state_q == ISSUE) & ~is_mult;
  assign md.operator_o         = operator_q;
  assign md.signed_mode_o      = signed_mode_q;
  assign md.op_a_o             = op_a_q;
  assign md.op_b_o             = op_b_q;
  assign md.multdiv_ready_id_o = (state_q == ISSUE);
  assign md.rsp_valid_o        = (state_q == RESP);
  assign md.rsp_result_o       = result_q;
  assign md.busy_o             = (state_q != IDLE);
  assign md.timing_err_o       = timing_err_q;
  assign md.timeout_err_o      = timeout_err_q;

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
module tb_multdiv_issue_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   lat_cfg;
  bit   last_acc;
  bit   last_hs;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  sm;
    logic [31:0] a;
    logic [31:0] b;
    logic        dit;
    int          lat;
    logic        terr;
  } vec_t;

  vec_t vt[9];

  multdiv_issue_ctrl_if md();

  multdiv_issue_ctrl #(
    .MulCycles(33),
    .DivCycles(37),
    .TimeoutCycles(63)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .md    (md)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stand-in arithmetic unit: any deterministic function of the issued
  // operator, mode and operands, so a wrong registered field shows up as a
  // wrong response value.
  function automatic logic [31:0] unit_fn(logic [1:0] op, logic [1:0] sm,
                                          logic [31:0] a, logic [31:0] b);
    logic [63:0] p;
    logic [31:0] r;
    p = {32'd0, a} * {32'd0, b};
    case (op)
      2'd0:    r = p[31:0];
      2'd1:    r = p[63:32];
      2'd2:    r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      default: r = (b == 32'd0) ? a : a % b;
    endcase
    return r ^ {30'd0, sm};
  endfunction

  // Unit model: counts cycles with an enable high and raises valid_i when the
  // count equals lat_cfg (0 means never).
  initial begin : unit_model
    int ucnt;
    ucnt = 0;
    md.valid_i  = 1'b0;
    md.result_i = 32'd0;
    forever begin
      @(negedge clk);
      if (md.mult_en_o || md.div_en_o) ucnt++;
      else ucnt = 0;
      md.valid_i  = (lat_cfg != 0) && (ucnt == lat_cfg);
      md.result_i = md.valid_i ? unit_fn(md.operator_o, md.signed_mode_o, md.op_a_o, md.op_b_o)
                               : 32'hDEAD_BEEF;
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock: observe handshakes at the falling edge, return just after the rising edge.
  task automatic cyc();
    @(negedge clk);
    last_acc = md.req_valid_i && md.req_ready_o;
    last_hs  = md.rsp_valid_o && md.rsp_ready_i;
    if (md.rsp_valid_o && exp_q.size() == 0)
      check("unexpected_rsp", 32'(md.rsp_valid_o), 32'd0);
    else if (last_hs)
      check("rsp_result", md.rsp_result_o, exp_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] sm, input logic [31:0] a,
                       input logic [31:0] b, input logic dit, input int lat, input bit expect_rsp);
    lat_cfg               = lat;
    md.req_operator_i     = op;
    md.req_signed_mode_i  = sm;
    md.req_op_a_i         = a;
    md.req_op_b_i         = b;
    md.data_ind_timing_i  = dit;
    md.req_valid_i        = 1'b1;
    last_acc              = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (last_acc) break;
    end
    if (!last_acc) check("req_accept", 32'd0, 32'd1);
    md.req_valid_i = 1'b0;
    if (last_acc && expect_rsp) exp_q.push_back(unit_fn(op, sm, a, b));
  endtask

  task automatic wait_rsp(input int budget, output int ncyc);
    md.rsp_ready_i = 1'b1;
    ncyc    = 0;
    last_hs = 1'b0;
    while (!last_hs && ncyc < budget) begin
      cyc();
      ncyc++;
    end
    if (!last_hs) check("rsp_wait_bound", 32'd0, 32'd1);
  endtask

  task automatic wait_rsp_valid(input int budget, output int ncyc);
    ncyc = 0;
    while (!md.rsp_valid_o && ncyc < budget) begin
      cyc();
      ncyc++;
    end
    if (!md.rsp_valid_o) check("rsp_valid_bound", 32'd0, 32'd1);
  endtask

  task automatic clear_errs();
    md.err_clear_i = 1'b1;
    cyc();
    md.err_clear_i = 1'b0;
  endtask

  initial begin : main
    int n;
    checks = 0;
    errors = 0;
    lat_cfg = 0;
    rst_n = 1'b0;
    md.req_valid_i = 1'b0;
    md.req_operator_i = 2'd0;
    md.req_signed_mode_i = 2'd0;
    md.req_op_a_i = 32'd0;
    md.req_op_b_i = 32'd0;
    md.data_ind_timing_i = 1'b0;
    md.flush_i = 1'b0;
    md.rsp_ready_i = 1'b0;
    md.err_clear_i = 1'b0;

    //          op     sm     a             b             dit   lat terr
    vt[0] = '{2'd0, 2'd0, 32'd7,        32'd6,        1'b1, 33, 1'b0};
    vt[1] = '{2'd1, 2'd1, 32'hFFFF_FFFF, 32'h0001_0000, 1'b1, 33, 1'b0};
    vt[2] = '{2'd2, 2'd0, 32'd100,      32'd7,        1'b1, 37, 1'b0};
    vt[3] = '{2'd3, 2'd2, 32'd100,      32'd7,        1'b1, 37, 1'b0};
    vt[4] = '{2'd2, 2'd0, 32'd1000,     32'd3,        1'b1, 36, 1'b1};
    vt[5] = '{2'd2, 2'd0, 32'd1000,     32'd3,        1'b0, 36, 1'b0};
    vt[6] = '{2'd0, 2'd3, 32'h1234_5678, 32'd16,      1'b1, 1,  1'b1};
    vt[7] = '{2'd2, 2'd1, 32'd55,       32'd0,        1'b1, 37, 1'b0};
    vt[8] = '{2'd0, 2'd0, 32'd9,        32'd9,        1'b0, 5,  1'b0};

    // Reset state
    repeat (2) begin @(posedge clk); #1; end
    check("rst_busy",      32'(md.busy_o), 32'd0);
    check("rst_req_ready", 32'(md.req_ready_o), 32'd1);
    check("rst_rsp_valid", 32'(md.rsp_valid_o), 32'd0);
    check("rst_enables",   32'({md.mult_en_o, md.div_en_o, md.mult_sel_o, md.div_sel_o}), 32'd0);
    check("rst_errs",      32'({md.timing_err_o, md.timeout_err_o}), 32'd0);
    check("rst_op_a",      md.op_a_o, 32'd0);
    rst_n = 1'b1;
    cyc();

    // MULL 7*6 with the response held off for 3 cycles
    md.rsp_ready_i = 1'b0;
    issue(2'd0, 2'd0, 32'd7, 32'd6, 1'b1, 33, 1'b1);
    check("mull_issue_en", 32'({md.mult_en_o, md.mult_sel_o, md.div_en_o, md.div_sel_o}), 32'b1100);
    check("mull_ready_id", 32'(md.multdiv_ready_id_o), 32'd1);
    check("mull_op_a", md.op_a_o, 32'd7);
    wait_rsp_valid(60, n);
    check("mull_rsp_latency", 32'(n), 32'd33);
    check("mull_result", md.rsp_result_o, 32'd42);
    check("mull_timing_err", 32'(md.timing_err_o), 32'd0);
    check("resp_ready_id", 32'(md.multdiv_ready_id_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("mull_hold_valid", 32'(md.rsp_valid_o), 32'd1);
      check("mull_hold_result", md.rsp_result_o, 32'd42);
    end
    wait_rsp(4, n);
    check("mull_idle_after", 32'(md.busy_o), 32'd0);

    // Vector table: result, exact latency, timing error and its clearing
    foreach (vt[i]) begin
      md.rsp_ready_i = 1'b0;
      issue(vt[i].op, vt[i].sm, vt[i].a, vt[i].b, vt[i].dit, vt[i].lat, 1'b1);
      wait_rsp(80, n);
      check($sformatf("v%0d_latency", i), 32'(n), 32'(vt[i].lat + 1));
      check($sformatf("v%0d_timing_err", i), 32'(md.timing_err_o), 32'(vt[i].terr));
      if (vt[i].terr) begin
        cyc();
        check($sformatf("v%0d_timing_sticky", i), 32'(md.timing_err_o), 32'd1);
      end
      clear_errs();
      check($sformatf("v%0d_timing_cleared", i), 32'(md.timing_err_o), 32'd0);
    end

    // Error set outranks a simultaneous clear
    md.rsp_ready_i = 1'b0;
    md.err_clear_i = 1'b1;
    issue(2'd2, 2'd0, 32'd1000, 32'd3, 1'b1, 36, 1'b1);
    wait_rsp_valid(60, n);
    md.err_clear_i = 1'b0;
    check("set_beats_clear", 32'(md.timing_err_o), 32'd1);
    wait_rsp(4, n);
    clear_errs();

    // REM timeout: unit never answers
    issue(2'd3, 2'd0, 32'd100, 32'd7, 1'b1, 0, 1'b0);
    n = 0;
    while (md.busy_o && n < 80) begin
      cyc();
      n++;
    end
    check("to_abort_cycle", 32'(n), 32'd63);
    check("to_err", 32'(md.timeout_err_o), 32'd1);
    check("to_enables", 32'({md.mult_en_o, md.div_en_o}), 32'd0);
    check("to_req_ready", 32'(md.req_ready_o), 32'd1);
    check("to_rsp_valid", 32'(md.rsp_valid_o), 32'd0);
    check("to_timing_err", 32'(md.timing_err_o), 32'd0);
    cyc();
    check("to_sticky", 32'(md.timeout_err_o), 32'd1);
    clear_errs();
    check("to_cleared", 32'(md.timeout_err_o), 32'd0);

    // Back-to-back: new MULH accepted in the cycle the response is consumed
    md.rsp_ready_i = 1'b0;
    issue(2'd0, 2'd0, 32'd3, 32'd5, 1'b0, 4, 1'b1);
    wait_rsp_valid(20, n);
    md.rsp_ready_i = 1'b1;
    issue(2'd1, 2'd1, 32'hFFFF_FFFF, 32'h10, 1'b1, 33, 1'b1);
    check("b2b_mult_en", 32'(md.mult_en_o), 32'd1);
    check("b2b_busy", 32'(md.busy_o), 32'd1);
    check("b2b_rsp_valid", 32'(md.rsp_valid_o), 32'd0);
    wait_rsp(60, n);
    check("b2b_latency", 32'(n), 32'd34);
    check("b2b_timing_err", 32'(md.timing_err_o), 32'd0);

    // Flush in the same cycle as unit valid during a DIV
    md.rsp_ready_i = 1'b0;
    issue(2'd2, 2'd0, 32'd50, 32'd5, 1'b1, 10, 1'b0);
    repeat (9) cyc();
    md.flush_i = 1'b1;
    cyc();
    check("flush_overlap_valid", 32'(md.valid_i), 32'd1);
    check("flush_req_ready", 32'(md.req_ready_o), 32'd0);
    check("flush_busy", 32'(md.busy_o), 32'd0);
    md.flush_i = 1'b0;
    repeat (5) cyc();
    check("flush_rsp_valid", 32'(md.rsp_valid_o), 32'd0);
    check("flush_errs", 32'({md.timing_err_o, md.timeout_err_o}), 32'd0);

    // Reset in the middle of a DIV issue
    issue(2'd2, 2'd0, 32'd9, 32'd3, 1'b1, 37, 1'b0);
    repeat (5) cyc();
    rst_n = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    check("mrst_busy", 32'(md.busy_o), 32'd0);
    check("mrst_enables", 32'({md.mult_en_o, md.div_en_o, md.mult_sel_o, md.div_sel_o}), 32'd0);
    check("mrst_rsp_valid", 32'(md.rsp_valid_o), 32'd0);
    check("mrst_operands", md.op_a_o | md.op_b_o | 32'(md.operator_o), 32'd0);
    md.rsp_ready_i = 1'b1;
    repeat (45) cyc();
    check("mrst_no_rsp", 32'(md.rsp_valid_o), 32'd0);
    check("mrst_no_err", 32'({md.timing_err_o, md.timeout_err_o}), 32'd0);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multdiv_issue_ctrl.md
Name: multdiv_issue_ctrl

Overview:
- ID-side initiator for the multiply/divide unit.
- Accepts one mult/div request on a valid/ready handshake and registers its operator, signed mode and operands. Drives the unit's enable/select/operand inputs, holds them stable until the unit's valid arrives, then presents the result on a valid/ready response port.
- With data-independent timing enabled, it checks that every operation completes in exactly the fixed cycle count, and aborts on timeout.

Parameters:
- MulCycles, 33, required issue-to-valid cycle count for MD_OP_MULL/MD_OP_MULH.
- DivCycles, 37, required issue-to-valid cycle count for MD_OP_DIV/MD_OP_REM.
- TimeoutCycles, 63, cycle count at which an outstanding op is aborted (must exceed both above, max 63).

Ports:
- Clock and reset:
  - clk_i  in  1  clock.
  - rst_ni  in  1  reset; synchronous, active-low.
- Request side:
  - req_valid_i  in  1  request valid.
  - req_ready_o  out  1  request accepted when high with req_valid_i.
  - req_operator_i  in  2  cve2_pkg::md_op_e (MULL=0, MULH=1, DIV=2, REM=3).
  - req_signed_mode_i  in  2  signed mode.
  - req_op_a_i  in  32  operand a.
  - req_op_b_i  in  32  operand b.
  - data_ind_timing_i  in  1  timing-check enable, sampled at accept.
  - flush_i  in  1  abort any outstanding op.
- Unit side:
  - mult_en_o  out  1  unit multiply enable.
  - div_en_o  out  1  unit divide enable.
  - mult_sel_o  out  1  unit multiply select.
  - div_sel_o  out  1  unit divide select.
  - operator_o  out  2  registered operator.
  - signed_mode_o  out  2  registered signed mode.
  - op_a_o  out  32  registered operand a.
  - op_b_o  out  32  registered operand b.
  - multdiv_ready_id_o  out  1  ID ready to consume unit result.
  - valid_i  in  1  unit result valid.
  - result_i  in  32  unit result.
- Response and status:
  - rsp_valid_o  out  1  response valid.
  - rsp_ready_i  in  1  response consumer ready.
  - rsp_result_o  out  32  captured result.
  - busy_o  out  1  state != IDLE.
  - timing_err_o  out  1  sticky latency mismatch.
  - timeout_err_o  out  1  sticky timeout.
  - err_clear_i  in  1  clears both sticky errors.

Behaviour:
- Reset (rst_ni low at clock edge):
  - state=IDLE, counter=0, all registers and outputs 0.
  - Applies from any state; an outstanding op is dropped with no response.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i: latch operator, signed mode, operands and data_ind_timing_i; counter<=1; go to ISSUE.
- ISSUE:
  - mult_en_o=mult_sel_o=1 for MULL/MULH; div_en_o=div_sel_o=1 for DIV/REM; exactly one pair high.
  - operator_o, signed_mode_o, op_a_o, op_b_o held constant.
  - multdiv_ready_id_o=1 throughout ISSUE, 0 in all other states.
  - Counter increments each cycle, saturating at 63.
  - On valid_i: capture result_i into rsp_result_o; go to RESP.
  - If the latched timing flag is set and counter != expected (MulCycles or DivCycles by operator): set timing_err_o in the same edge.
  - If counter == TimeoutCycles and valid_i is low: set timeout_err_o, drop enables, go to IDLE, produce no response.
- RESP:
  - rsp_valid_o=1; rsp_result_o is stable until handshake.
  - On rsp_ready_i: go to IDLE.
  - req_ready_o = rsp_ready_i, allowing back-to-back issue. A request accepted in the same cycle goes directly to ISSUE with counter<=1.
- flush_i:
  - In ISSUE or RESP: go to IDLE next edge, drop enables and rsp_valid_o, no error set.
  - flush_i and valid_i in the same cycle: flush wins, result discarded.
  - req_ready_o=0 while flush_i is high.
- Errors:
  - timing_err_o and timeout_err_o are sticky until err_clear_i.
  - A set condition in the same cycle as err_clear_i wins (the bit stays 1).
- Counter semantics: counter=1 in the first cycle enables are high. valid_i in that same cycle means latency 1.
- Divide-by-zero or overflow operands: no special handling; timing is still checked.
- Combinational dependencies:
  - req_ready_o depends combinationally on state, rsp_ready_i and flush_i only.
  - Enables and select outputs are decoded from registered state only.

Test Plan:
- Reset: hold rst_ni=0 for 2 cycles during ISSUE of a DIV -> next cycle busy_o=0, all enables=0, rsp_valid_o=0, no response ever appears.
- MULL, data_ind_timing=1, a=7, b=6; model returns valid_i with 42 at counter=33 -> rsp_valid_o=1 with 42 one cycle later, timing_err_o=0; hold rsp_ready_i=0 for 3 cycles -> result stable throughout.
- DIV, data_ind_timing=1; valid_i at counter=36 -> timing_err_o=1 and sticky; pulse err_clear_i -> 0 next cycle. Repeat with data_ind_timing=0 -> no error.
- REM, model never asserts valid_i -> timeout_err_o=1 after counter=63, enables drop next cycle, req_ready_o=1, no rsp_valid_o.
- Back-to-back: in RESP, rsp_ready_i=1 with new MULH request -> next cycle state ISSUE with mult_en_o=1 and counter=1, no idle bubble.
- flush_i asserted in the same cycle as valid_i during a DIV -> IDLE next cycle, rsp_valid_o never set, no error flags.
